// File: rtl/vga_controller.sv
// vga_controller: 640x480 VGA timing, 8x6 cell grid with button cursor/selection and a processor mailbox; define CURSOR_WRAP_EN for wrapping cursor moves
module vga_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL     = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BTND_in,
    input  logic        BTNU_in,
    input  logic        BTNL_in,
    input  logic        BTNR_in,
    input  logic        BTNC_in,
    input  logic [3:0]  SW,
    output logic        hSync,
    output logic        vSync,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] from_processor,
    output logic [31:0] to_processor
);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] CELL_W   = 10'(CELL);
    localparam logic [2:0] X_MAX    = 3'(H_ACTIVE / CELL - 1);
    localparam logic [2:0] Y_MAX    = 3'(V_ACTIVE / CELL - 1);

    logic [9:0]  h_count, v_count, cx, cy;
    logic [4:0]  btn, btn_prev, btn_rise;
    logic [2:0]  cur_x, cur_y, sel_x, sel_y, nx_x, nx_y;
    logic        sel_valid, active, unused_ok;
    logic [31:0] proc_reg;
    logic [11:0] colour;

    // bit order {C,U,D,L,R} matches the status word layout
    assign btn       = {BTNC_in, BTNU_in, BTND_in, BTNL_in, BTNR_in};
    assign btn_rise  = btn & ~btn_prev;
    assign unused_ok = &{1'b0, ps2_clk, ps2_data, SW[2:0], proc_reg[31:12]};

    // Pixel and line counters; the line advances when the pixel counter wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else begin
            h_count <= (h_count == H_LAST) ? '0 : h_count + 10'd1;
            if (h_count == H_LAST)
                v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
        end
    end

    assign hSync  = reset | ~(h_count >= HS_FIRST && h_count <= HS_LAST);
    assign vSync  = reset | ~(v_count >= VS_FIRST && v_count <= VS_LAST);
    assign cx     = h_count / CELL_W;
    assign cy     = v_count / CELL_W;
    assign active = ~reset & (h_count < H_VIS) & (v_count < V_VIS);

    // Pixel colour by priority: grid line, cursor, selection, background
    always_comb begin
        colour = !active ? 12'h000
               : (h_count % CELL_W == 10'd0 || v_count % CELL_W == 10'd0) ? 12'hFFF
               : (cx == {7'd0, cur_x} && cy == {7'd0, cur_y}) ? 12'hFF0
               : (sel_valid && cx == {7'd0, sel_x} && cy == {7'd0, sel_y}) ? 12'h0F0
               : SW[3] ? proc_reg[11:0] : 12'h00F;
    end

    assign {VGA_R, VGA_G, VGA_B} = colour;

    // Next cursor position from this cycle's button edges; opposing edges cancel
    always_comb begin
`ifdef CURSOR_WRAP_EN
        nx_x = (btn_rise[1] && !btn_rise[0]) ? ((cur_x == 3'd0) ? X_MAX : cur_x - 3'd1)
             : (btn_rise[0] && !btn_rise[1]) ? ((cur_x == X_MAX) ? 3'd0 : cur_x + 3'd1)
             : cur_x;
        nx_y = (btn_rise[3] && !btn_rise[2]) ? ((cur_y == 3'd0) ? Y_MAX : cur_y - 3'd1)
             : (btn_rise[2] && !btn_rise[3]) ? ((cur_y == Y_MAX) ? 3'd0 : cur_y + 3'd1)
             : cur_y;
`else
        nx_x = (btn_rise[1] && !btn_rise[0]) ? ((cur_x == 3'd0) ? 3'd0 : cur_x - 3'd1)
             : (btn_rise[0] && !btn_rise[1]) ? ((cur_x == X_MAX) ? X_MAX : cur_x + 3'd1)
             : cur_x;
        nx_y = (btn_rise[3] && !btn_rise[2]) ? ((cur_y == 3'd0) ? 3'd0 : cur_y - 3'd1)
             : (btn_rise[2] && !btn_rise[3]) ? ((cur_y == Y_MAX) ? Y_MAX : cur_y + 3'd1)
             : cur_y;
`endif
    end

    // Button history, cursor, selection toggle, mailbox and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev     <= '0;
            cur_x        <= '0;
            cur_y        <= '0;
            sel_x        <= '0;
            sel_y        <= '0;
            sel_valid    <= 1'b0;
            proc_reg     <= '0;
            to_processor <= '0;
        end else begin
            btn_prev <= btn;
            cur_x    <= nx_x;
            cur_y    <= nx_y;
            if (btn_rise[4]) begin
                sel_x     <= cur_x;
                sel_y     <= cur_y;
                sel_valid <= !(sel_valid && cur_x == sel_x && cur_y == sel_y);
            end
            if (from_processor != '0)
                proc_reg <= from_processor;
            to_processor <= {14'd0, btn, sel_valid, sel_y, sel_x, cur_y, cur_x};
        end
    end
endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: bench for vga_controller on a scaled-down raster (same 8x6 grid), with and without CURSOR_WRAP_EN
module tb_vga_controller;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int C = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int GX = HA / C, GY = VA / C;

    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  btn = '0;
    logic [3:0]  sw = '0;
    logic [31:0] from_p = '0;
    logic        hsync, vsync;
    logic [3:0]  r, g, b;
    logic [31:0] to_p;

    int compared = 0, mismatched = 0;

    int          t, mx, my, msx, msy;
    bit          mv;
    logic [4:0]  mprev;
    logic [31:0] mproc, mto;

    typedef struct {
        bit         rs;
        logic [4:0] btn;
        int         n;
        int         hold;
        int         ex;
        int         ey;
        logic [6:0] esel;
    } vec_t;
    vec_t tbl[12];

    vga_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CELL(C)
    ) dut (
        .clk(clk), .reset(rst),
        .BTND_in(btn[2]), .BTNU_in(btn[3]), .BTNL_in(btn[1]), .BTNR_in(btn[0]), .BTNC_in(btn[4]),
        .SW(sw), .hSync(hsync), .vSync(vsync), .VGA_R(r), .VGA_G(g), .VGA_B(b),
        .ps2_clk(1'b0), .ps2_data(1'b0),
        .from_processor(from_p), .to_processor(to_p)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (h=%0d v=%0d)", name, got, want, t % HT, t / HT);
        end
    endtask

    task automatic model_reset();
        t = 0; mx = 0; my = 0; msx = 0; msy = 0; mv = 0;
        mprev = '0; mproc = '0; mto = '0;
    endtask

    function automatic logic [11:0] exp_colour();
        int h = t % HT;
        int v = t / HT;
        if (rst || h >= HA || v >= VA) return 12'h000;
        if (h % C == 0 || v % C == 0) return 12'hFFF;
        if (h / C == mx && v / C == my) return 12'hFF0;
        if (mv && h / C == msx && v / C == msy) return 12'h0F0;
        return sw[3] ? mproc[11:0] : 12'h00F;
    endfunction

    task automatic model_step();
        logic [4:0] e;
        int ox, oy;
        logic [31:0] nto;
        if (rst) return;
        nto = {14'd0, btn, mv, 3'(msy), 3'(msx), 3'(my), 3'(mx)};
        e = btn & ~mprev;
        mprev = btn;
        ox = mx;
        oy = my;
`ifdef CURSOR_WRAP_EN
        if (e[1] && !e[0]) mx = (mx + GX - 1) % GX;
        if (e[0] && !e[1]) mx = (mx + 1) % GX;
        if (e[3] && !e[2]) my = (my + GY - 1) % GY;
        if (e[2] && !e[3]) my = (my + 1) % GY;
`else
        if (e[1] && !e[0]) mx = (mx > 0) ? mx - 1 : 0;
        if (e[0] && !e[1]) mx = (mx < GX - 1) ? mx + 1 : GX - 1;
        if (e[3] && !e[2]) my = (my > 0) ? my - 1 : 0;
        if (e[2] && !e[3]) my = (my < GY - 1) ? my + 1 : GY - 1;
`endif
        if (e[4]) begin
            if (mv && ox == msx && oy == msy) mv = 0;
            else begin
                msx = ox; msy = oy; mv = 1;
            end
        end
        if (from_p != 0) mproc = from_p;
        t = (t + 1) % FRAME;
        mto = nto;
    endtask

    task automatic check();
        int h = t % HT;
        int v = t / HT;
        cmp("hsync", 32'(hsync), 32'(rst || h < HA + HF || h >= HA + HF + HS));
        cmp("vsync", 32'(vsync), 32'(rst || v < VA + VF || v >= VA + VF + VS));
        cmp("rgb", {20'd0, r, g, b}, {20'd0, exp_colour()});
        cmp("status", to_p, mto);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1 check();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_pixel(input int h, input int v);
        int k = 0;
        do begin
            tick();
            k++;
        end while (t != v * HT + h && k < FRAME + 2);
    endtask

    initial begin
        int hfall = 0, hrun = 0, vrun = 0, vf1 = -1, vf2 = -1;
        logic ph = 1'b1, pv = 1'b1;

        tbl[0]  = '{1'b0, 5'b00001, 3, 5, 3, 0, 7'd0};
        tbl[1]  = '{1'b0, 5'b00100, 2, 5, 3, 2, 7'd0};
`ifdef CURSOR_WRAP_EN
        tbl[2]  = '{1'b1, 5'b00010, 1, 5, 7, 0, 7'd0};
        tbl[3]  = '{1'b0, 5'b00100, 7, 5, 7, 1, 7'd0};
        tbl[4]  = '{1'b0, 5'b00011, 1, 5, 7, 1, 7'd0};
        tbl[5]  = '{1'b0, 5'b01000, 1, 100, 7, 0, 7'd0};
`else
        tbl[2]  = '{1'b1, 5'b00010, 1, 5, 0, 0, 7'd0};
        tbl[3]  = '{1'b0, 5'b00100, 7, 5, 0, 5, 7'd0};
        tbl[4]  = '{1'b0, 5'b00011, 1, 5, 0, 5, 7'd0};
        tbl[5]  = '{1'b0, 5'b01000, 1, 100, 0, 4, 7'd0};
`endif
        tbl[6]  = '{1'b1, 5'b00001, 1, 5, 1, 0, 7'd0};
        tbl[7]  = '{1'b0, 5'b00100, 1, 5, 1, 1, 7'd0};
        tbl[8]  = '{1'b0, 5'b10000, 1, 5, 1, 1, 7'b1001001};
        tbl[9]  = '{1'b0, 5'b00001, 1, 5, 2, 1, 7'b1001001};
        tbl[10] = '{1'b0, 5'b00010, 1, 5, 1, 1, 7'b1001001};
        tbl[11] = '{1'b0, 5'b10000, 1, 5, 1, 1, 7'b0001001};

        model_reset();
        #1 check();
        cmp("reset_status", to_p, 32'd0);
        cmp("reset_rgb", {20'd0, r, g, b}, 32'd0);
        cmp("reset_syncs", {30'd0, hsync, vsync}, 32'd3);
        tick();
        tick();
        rst = 1'b0;

        // two full frames of timing
        for (int i = 1; i <= 2 * FRAME; i++) begin
            tick();
            if (ph && !hsync) begin
                if (i <= FRAME) hfall++;
                cmp("hsync_start", t % HT, HA + HF);
            end
            if (!hsync) hrun++;
            else begin
                if (!ph) cmp("hsync_width", hrun, HS);
                hrun = 0;
            end
            if (!vsync) vrun++;
            else begin
                if (!pv) cmp("vsync_width", vrun, VS * HT);
                vrun = 0;
            end
            if (pv && !vsync) begin
                if (vf1 < 0) vf1 = i;
                else if (vf2 < 0) vf2 = i;
            end
            ph = hsync;
            pv = vsync;
        end
        cmp("hsync_per_frame", hfall, VT);
        cmp("vsync_start", vf1, (VA + VF) * HT);
        cmp("frame_period", vf2 - vf1, FRAME);

        // cursor/selection vectors
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rs) do_reset();
            for (int p = 0; p < tbl[i].n; p++) begin
                btn = tbl[i].btn;
                repeat (tbl[i].hold) tick();
                btn = '0;
                repeat (5) tick();
            end
            cmp($sformatf("vec%0d_cursor", i), {26'd0, to_p[5:0]}, {26'd0, 3'(tbl[i].ey), 3'(tbl[i].ex)});
            cmp($sformatf("vec%0d_sel", i), {25'd0, to_p[12:6]}, {25'd0, tbl[i].esel});
            cmp($sformatf("vec%0d_raw", i), {27'd0, to_p[17:13]}, 32'd0);
            if (i == 1) begin
                wait_pixel(3 * C, 2 * C);
                cmp("pix_grid", {20'd0, r, g, b}, 32'hFFF);
                wait_pixel(3 * C + 3, 2 * C + 3);
                cmp("pix_cursor", {20'd0, r, g, b}, 32'hFF0);
            end
            if (i == 9) begin
                wait_pixel(C + 3, C + 3);
                cmp("pix_selected", {20'd0, r, g, b}, 32'h0F0);
            end
        end

        // button already high when reset releases
        btn = 5'b00001;
        do_reset();
        repeat (3) tick();
        cmp("held_at_release", {29'd0, to_p[2:0]}, 32'd1);
        btn = '0;
        repeat (3) tick();

        // mailbox background
        sw = 4'b1000;
        from_p = 32'h0000_0F00;
        tick();
        from_p = '0;
        wait_pixel(5 * C + 3, 4 * C + 3);
        cmp("bg_mailbox", {20'd0, r, g, b}, 32'hF00);
        wait_pixel(5 * C + 3, 4 * C + 3);
        cmp("bg_mailbox_held", {20'd0, r, g, b}, 32'hF00);
        sw = 4'b0000;
        #1 cmp("bg_default", {20'd0, r, g, b}, 32'h00F);

        // asynchronous reset mid-line in active, hsync and vsync regions
        wait_pixel(5 * C + 2, 2 * C + 4);
        rst = 1'b1;
        model_reset();
        #1 cmp("midline_rgb", {20'd0, r, g, b}, 32'd0);
        cmp("midline_syncs", {30'd0, hsync, vsync}, 32'd3);
        tick();
        rst = 1'b0;
        wait_pixel(HA + HF + 2, 5);
        cmp("in_hsync", 32'(hsync), 32'd0);
        rst = 1'b1;
        model_reset();
        #1 cmp("hsync_reset", 32'(hsync), 32'd1);
        tick();
        rst = 1'b0;
        wait_pixel(5, VA + VF);
        cmp("in_vsync", 32'(vsync), 32'd0);
        rst = 1'b1;
        model_reset();
        #1 cmp("vsync_reset", 32'(vsync), 32'd1);
        tick();
        rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            for (int j = 0; j < 5; j++)
                if ($urandom_range(0, 9) == 0) btn[j] = ~btn[j];
            from_p = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            if ($urandom_range(0, 63) == 0) sw = 4'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1;
                model_reset();
                #1 check();
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
